// File: rtl/uart_pkg.sv
// Shared UART definitions for the debug UART RX and TX paths.
// Holds the receive FSM states and the bit-timing helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int clks_per_bit(
    input int clk_rate,
    input int baud_rate
  );
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered read data.
// Shared by the debug UART receive and transmit paths.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk
    $error("uart_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic [WIDTH-1:0] r_rdata;

  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;

  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign w_pop  = i_pop && !r_empty;
  assign w_push = i_push && (!r_full || w_pop);
  assign o_drop = i_push && r_full && !w_pop;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign o_rdata = r_rdata;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/uart_rx_buffered.sv
// Debug UART receive path: 2-FF synchronizer, deserializer FSM
// and byte FIFO read by the DMI UART TAP.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 3000000,
  parameter int DEPTH     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       re_i,
  output logic [7:0] dout_o,
  output logic       rx_empty_o,
  output logic       rx_full_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CPB  = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int BW   = $clog2(CPB);
  localparam int NW   = $clog2(UART_DATA_BITS);

  if (CPB < 4) begin : g_chk
    $error("uart_rx_buffered: CLK_RATE/BAUD_RATE must be >= 4");
  end

  logic [1:0]                r_sync;
  rx_state_e                 r_state;
  rx_state_e                 w_state_nxt;
  logic [BW-1:0]             r_baud;
  logic [NW-1:0]             r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_rxs;
  logic w_half_done;
  logic w_bit_done;
  logic w_last_bit;
  logic w_baud_clr;
  logic w_shift;
  logic w_push;
  logic w_ferr;
  logic w_drop;

  assign w_rxs       = r_sync[1];
  assign w_half_done = (r_baud == BW'(HALF - 1));
  assign w_bit_done  = (r_baud == BW'(CPB - 1));
  assign w_last_bit  = (r_bit_cnt == NW'(UART_DATA_BITS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (!w_rxs) w_state_nxt = START;
      end
      START: begin
        if (w_half_done) w_state_nxt = w_rxs ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_done && w_last_bit) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done) w_state_nxt = w_rxs ? IDLE : BREAK;
      end
      BREAK: begin
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_baud_clr = 1'b0;
    w_shift    = 1'b0;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    unique case (r_state)
      IDLE:  w_baud_clr = 1'b1;
      START: w_baud_clr = w_half_done;
      DATA: begin
        w_baud_clr = w_bit_done;
        w_shift    = w_bit_done;
      end
      STOP: begin
        w_baud_clr = w_bit_done;
        w_push     = w_bit_done && w_rxs;
        w_ferr     = w_bit_done && !w_rxs;
      end
      BREAK: w_baud_clr = 1'b1;
      default: w_baud_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync      <= 2'b11;
      r_baud      <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_i};
      r_baud <= w_baud_clr ? '0 : r_baud + BW'(1);
      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + NW'(1);
        r_shift   <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
      end else if (r_state != DATA) begin
        r_bit_cnt <= '0;
      end
      r_frame_err <= w_ferr;
      r_overrun   <= w_drop;
    end
  end

  uart_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_push (w_push),
    .i_wdata(r_shift),
    .i_pop  (re_i),
    .o_rdata(dout_o),
    .o_empty(rx_empty_o),
    .o_full (rx_full_o),
    .o_drop (w_drop)
  );

  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized bench for uart_rx_buffered against a queue-based
// model of the byte stream, frame errors and overruns.
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int FLEN  = 10 * CPB;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       re_i;
  logic [7:0] dout_o;
  logic       rx_empty_o;
  logic       rx_full_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx_buffered #(
    .CLK_RATE (16),
    .BAUD_RATE(1),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .re_i       (re_i),
    .dout_o     (dout_o),
    .rx_empty_o (rx_empty_o),
    .rx_full_o  (rx_full_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic emp_mid;

  logic [7:0] q[$];
  logic [7:0] last_dout;

  always @(negedge clk_i) begin
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n, input logic v);
    rx_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One 10-bit frame; optional pop or reset in a given cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int pop_c, input int rst_c);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int c = 0; c < FLEN; c++) begin
      rx_i  = fr[c/CPB];
      re_i  = (c == pop_c);
      rst_i = (c == rst_c);
      @(posedge clk_i);
      #1;
      if (c == 149) emp_mid = rx_empty_o;
      if (c == rst_c) begin
        rst_i = 1'b0;
        rx_i  = 1'b1;
        re_i  = 1'b0;
        return;
      end
    end
    re_i = 1'b0;
  endtask

  task automatic rx_good(input logic [7:0] d, input string tag);
    int o;
    bit full_before;
    o = n_ovr;
    full_before = (q.size() == DEPTH);
    send_frame(d, 1'b1, -1, -1);
    if (!full_before) q.push_back(d);
    chk({tag, "_ovr"}, n_ovr - o, full_before ? 1 : 0);
    chk({tag, "_full"}, rx_full_o, q.size() == DEPTH);
    chk({tag, "_empty"}, rx_empty_o, q.size() == 0);
  endtask

  task automatic pop(input string tag);
    re_i = 1'b1;
    @(posedge clk_i);
    #1;
    re_i = 1'b0;
    if (q.size() > 0) last_dout = q.pop_front();
    chk({tag, "_dout"}, dout_o, last_dout);
    chk({tag, "_empty"}, rx_empty_o, q.size() == 0);
  endtask

  initial begin
    int f0, o0;
    logic [7:0] b, head;
    rst_i = 1'b1;
    rx_i  = 1'b1;
    re_i  = 1'b0;
    last_dout = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_dout", dout_o, 8'h00);
    chk("rst_empty", rx_empty_o, 1'b1);
    chk("rst_full", rx_full_o, 1'b0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_ovr", overrun_o, 1'b0);
    rst_i = 1'b0;
    idle(4, 1'b1);

    // single byte
    send_frame(8'hA5, 1'b1, -1, -1);
    q.push_back(8'hA5);
    chk("t1_empty_pre", emp_mid, 1'b1);
    chk("t1_empty_post", rx_empty_o, 1'b0);
    pop("t1_pop");

    // short low glitch
    f0 = n_ferr;
    o0 = n_ovr;
    idle(4, 1'b0);
    idle(40, 1'b1);
    chk("t2_empty", rx_empty_o, 1'b1);
    chk("t2_ferr", n_ferr - f0, 0);
    chk("t2_ovr", n_ovr - o0, 0);

    // framing error followed by a long break
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(40, 1'b0);
    idle(16, 1'b1);
    chk("t3_ferr", n_ferr - f0, 1);
    chk("t3_empty", rx_empty_o, 1'b1);
    rx_good(8'h81, "t3_rx");
    pop("t3_pop");

    // fill and overflow
    for (int i = 0; i <= DEPTH; i++) rx_good(8'(i), "t4_rx");
    for (int i = 0; i < DEPTH; i++) pop("t4_pop");

    // pop in the exact push cycle of a full FIFO
    for (int i = 0; i < DEPTH; i++) rx_good(8'($urandom), "t5_fill");
    o0 = n_ovr;
    head = q.pop_front();
    send_frame(8'h55, 1'b1, 154, -1);
    q.push_back(8'h55);
    last_dout = head;
    chk("t5_dout", dout_o, head);
    chk("t5_ovr", n_ovr - o0, 0);
    chk("t5_full", rx_full_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop("t5_pop");
    chk("t5_last", last_dout, 8'h55);

    // reset mid-frame with bytes queued
    rx_good(8'h11, "t6_q");
    rx_good(8'h22, "t6_q");
    send_frame(8'h77, 1'b1, -1, 50);
    q.delete();
    last_dout = 8'h00;
    chk("t6_empty", rx_empty_o, 1'b1);
    chk("t6_dout", dout_o, 8'h00);
    idle(20, 1'b1);
    rx_good(8'h12, "t6_rx");
    pop("t6_pop");

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        f0 = n_ferr;
        o0 = n_ovr;
        send_frame(b, 1'b0, -1, -1);
        idle(20, 1'b0);
        idle(16, 1'b1);
        chk("rnd_ferr", n_ferr - f0, 1);
        chk("rnd_ovr0", n_ovr - o0, 0);
        chk("rnd_cnt", rx_empty_o, q.size() == 0);
      end else begin
        rx_good(b, "rnd_rx");
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) pop("rnd_pop");
    end
    while (q.size() > 0) pop("drain");
    pop("empty_pop");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
